mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle MIPS multiply/divide unit producing the HI/LO pair for MULT, MULTU, DIV and DIVU. It sits directly upstream of the write-back result selector, which picks between the ALU result and `hi_o`/`lo_o` for MFHI/MFLO. The controller launches an operation with a start pulse, holds the pipeline on `busy_o`, and samples the result on `done_o`.

## Interface
- `size`, 32: operand and result width.
- `clk_i`, input, 1: clock; all state changes on the rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `start_i`, input, 1: launch request; sampled only in IDLE.
- `op_i`, input, 2: operation select, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src1_i`, input, size: multiplicand or dividend.
- `src2_i`, input, size: multiplier or divisor.
- `busy_o`, output, 1: operation in progress.
- `done_o`, output, 1: one-cycle pulse; `hi_o`/`lo_o` are valid from this cycle on.
- `hi_o`, output, size: product high half, or remainder.
- `lo_o`, output, size: product low half, or quotient.

## Operation
- States:
  - IDLE → CALC on `start_i`.
  - CALC → FIX after `size` iterations.
  - FIX → IDLE unconditionally.
- IDLE with `start_i`=1: latch `op_i`.
  - Signed ops: latch |`src1_i`| and |`src2_i`|, plus the result sign bits.
  - Unsigned ops: latch the raw operands.
  - Clear the accumulator and load the iteration counter with `size`-1.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle; 2·size-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle; size+1-bit partial remainder.
- FIX: apply sign correction, write the registered `hi_o`/`lo_o`, and assert `done_o`.
  - Signed multiply: negate the full 64-bit product when the operand signs differ.
  - Signed divide: quotient sign is the XOR of the operand signs; remainder sign follows the dividend.
- Divide by zero, any div op: `lo_o`=all ones, `hi_o`=original `src1_i`. Sign fix is bypassed. Latency is unchanged.
- Signed overflow, −2^31 / −1: `lo_o`=0x80000000, `hi_o`=0. No trap.
- Arithmetic is modulo 2^size per half. Negation is two's complement; |−2^31| is treated as unsigned 2^31.
- `hi_o`/`lo_o` hold their value until the next FIX writes them.

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `hi_o`=0, `lo_o`=0, counter 0.
- `start_i` is sampled at edge E0. `busy_o`=1 from E0 through the FIX cycle, i.e. while in CALC or FIX.
- `done_o`=1 for exactly one cycle, after edge E33 (state FIX), alongside the new `hi_o`/`lo_o`. Fixed latency is 34 cycles for every op.
- `busy_o` deasserts after E34. A `start_i` in that same cycle is accepted, giving back-to-back operations with no bubble.
- `start_i` while `busy_o`=1 is ignored, with no effect on the running operation.
- Operand inputs are don't-care after E0.
- `rst_i` mid-operation: immediate return to IDLE and all outputs to reset values. The partial result is discarded and no `done_o` is produced.

## Configuration
- `MDU_SIGNED_EN` defined: MULT and DIV perform signed arithmetic as above.
- `MDU_SIGNED_EN` undefined:
  - `op_i[0]` is ignored; MULT behaves as MULTU and DIV as DIVU.
  - The absolute-value and sign-fix logic is removed; FIX only registers the results.
  - Latency and ports are unchanged.

## Structure
- Shared package `mdu_pkg` holds:
  - the op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - the state encoding `MDU_IDLE`, `MDU_CALC`, `MDU_FIX`;
  - the iteration count constant.
  - The control decoder imports the op encodings from it.
- One sub-module, `mdu_sign_fix`: combinational absolute-value on entry plus result negation in FIX. It is instantiated only under `MDU_SIGNED_EN`.
- Iteration datapath and FSM stay in `mul_div_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done_o` 34 cycles after start; `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001.
- MULT −3 × 5 → `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFF1. Without the macro: `hi_o`=0x00000004, `lo_o`=0xFFFFFFF1.
- DIVU 100 / 7 → `lo_o`=14, `hi_o`=2. DIV −7 / 2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
- DIV 0x12345678 / 0 → `lo_o`=0xFFFFFFFF, `hi_o`=0x12345678; DIV 0x80000000 / 0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0.
- Start a DIVU, pulse `start_i` again at cycle 10 with a different op → ignored, and only the first result appears. Then assert `start_i` in the `done_o` cycle → a second `done_o` arrives exactly 34 cycles later.
- Assert `rst_i` at cycle 15 of a MULT → `busy_o`/`hi_o`/`lo_o` go to 0 asynchronously, and no `done_o` appears in the following 40 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the MIPS multiply/divide unit: op encodings,
// FSM state encodings, iteration count and small op-decode helpers.
// Imported by mul_div_unit, mdu_sign_fix and the bench.
package mdu_pkg;

  // Operand/result width; one quotient or multiplier bit per iteration.
  localparam int MDU_SIZE = 32;
  localparam int MDU_ITER = MDU_SIZE;

  // op_i encodings
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // FSM state encodings
  localparam logic [1:0] MDU_IDLE = 2'b00;
  localparam logic [1:0] MDU_CALC = 2'b01;
  localparam logic [1:0] MDU_FIX  = 2'b10;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Handshake/result bundle between the pipeline controller and mul_div_unit.
// master: controller (drives start_i/op_i/src1_i/src2_i, samples busy/done/hi/lo).
// slave: the unit itself.
interface mul_div_unit_if #(
  parameter int size = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [size-1:0] src1_i;
  logic [size-1:0] src2_i;
  logic            busy_o;
  logic            done_o;
  logic [size-1:0] hi_o;
  logic [size-1:0] lo_o;

  modport master (
    output start_i, op_i, src1_i, src2_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Purely combinational sign handling for signed MULT/DIV.
// Ports: entry side (src1/src2 -> magnitudes + result sign bits) and exit side
// (raw hi/lo + latched sign bits -> sign-corrected hi/lo). Only built with MDU_SIGNED_EN.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int size = MDU_SIZE
) (
  // entry: operand magnitudes and result signs
  input  logic            op_signed,
  input  logic [size-1:0] src1,
  input  logic [size-1:0] src2,
  output logic [size-1:0] abs1,
  output logic [size-1:0] abs2,
  output logic            ent_neg_res,
  output logic            ent_neg_rem,
  // exit: sign correction of the raw unsigned result
  input  logic            is_div,
  input  logic            neg_res,
  input  logic            neg_rem,
  input  logic [size-1:0] raw_hi,
  input  logic [size-1:0] raw_lo,
  output logic [size-1:0] fix_hi,
  output logic [size-1:0] fix_lo
);
  logic                s1, s2;
  logic [2*size-1:0]   prod_neg;

  assign s1 = op_signed & src1[size-1];
  assign s2 = op_signed & src2[size-1];

  // |-2^(size-1)| wraps to itself, which reads correctly as unsigned 2^(size-1).
  assign abs1 = s1 ? (~src1 + 1'b1) : src1;
  assign abs2 = s2 ? (~src2 + 1'b1) : src2;

  // Product/quotient sign is the XOR; remainder follows the dividend.
  assign ent_neg_res = s1 ^ s2;
  assign ent_neg_rem = s1;

  // A product is negated as one double-width value so the borrow crosses halves.
  assign prod_neg = ~{raw_hi, raw_lo} + 1'b1;

  always_comb begin
    fix_hi = raw_hi;
    fix_lo = raw_lo;
    if (is_div) begin
      if (neg_res) fix_lo = ~raw_lo + 1'b1;
      if (neg_rem) fix_hi = ~raw_hi + 1'b1;
    end else if (neg_res) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide.
// Ports: clk_i, rst_i (async, active-high), mdu (mul_div_unit_if.slave: start/op/src1/src2
// in, busy/done/hi/lo out). Fixed 34-cycle latency; start ignored while busy except in FIX.
// Optional macro MDU_SIGNED_EN enables signed MULT/DIV; otherwise op_i[0] is ignored.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int size = MDU_ITER
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_div_unit_if.slave mdu
);
  localparam int CW = $clog2(size);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              iter_done;   // all iterations done; next CALC edge enters FIX
  logic              is_div_q;
  logic              done_q;
  logic [size-1:0]   opa;         // mul: multiplier (shifts right); div: dividend/quotient (shifts left)
  logic [size-1:0]   opb;         // mul: multiplicand; div: divisor
  logic [size-1:0]   src1_raw;    // original dividend, returned as HI on divide-by-zero
  logic [2*size-1:0] acc;         // mul: product; div: acc[size:0] is the partial remainder
  logic [size-1:0]   hi_q, lo_q;

  logic              launch;
  logic [size-1:0]   ent_a, ent_b;
  logic [size-1:0]   raw_hi, raw_lo, fix_hi, fix_lo;
  logic [size:0]     mul_sum, div_trial;
  logic              div_by_zero;

  // FIX also accepts a new start so operations can run back to back.
  assign launch = mdu.start_i && ((state == MDU_IDLE) || (state == MDU_FIX));

  assign raw_hi = is_div_q ? acc[size-1:0] : acc[2*size-1:size];
  assign raw_lo = is_div_q ? opa : acc[size-1:0];

  assign div_by_zero = is_div_q && (opb == '0);

`ifdef MDU_SIGNED_EN
  logic ent_neg_res, ent_neg_rem;
  logic neg_res_q, neg_rem_q;

  mdu_sign_fix #(.size(size)) u_sign_fix (
    .op_signed   (op_is_signed(mdu.op_i)),
    .src1        (mdu.src1_i),
    .src2        (mdu.src2_i),
    .abs1        (ent_a),
    .abs2        (ent_b),
    .ent_neg_res (ent_neg_res),
    .ent_neg_rem (ent_neg_rem),
    .is_div      (is_div_q),
    .neg_res     (neg_res_q),
    .neg_rem     (neg_rem_q),
    .raw_hi      (raw_hi),
    .raw_lo      (raw_lo),
    .fix_hi      (fix_hi),
    .fix_lo      (fix_lo)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (launch) begin
      neg_res_q <= ent_neg_res;
      neg_rem_q <= ent_neg_rem;
    end
  end
`else
  assign ent_a  = mdu.src1_i;
  assign ent_b  = mdu.src2_i;
  assign fix_hi = raw_hi;
  assign fix_lo = raw_lo;
`endif

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole product right.
  assign mul_sum = {1'b0, acc[2*size-1:size]} + (opa[0] ? {1'b0, opb} : '0);

  // One restoring-division step: shift in the next dividend bit and try
  // subtracting the divisor; a clear top bit means the subtraction fits.
  assign div_trial = {acc[size-1:0], opa[size-1]} - {1'b0, opb};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= MDU_IDLE;
      cnt       <= '0;
      iter_done <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      src1_raw  <= '0;
      acc       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        MDU_IDLE, MDU_FIX: begin
          if (launch) begin
            state     <= MDU_CALC;
            is_div_q  <= op_is_div(mdu.op_i);
            opa       <= ent_a;
            opb       <= ent_b;
            src1_raw  <= mdu.src1_i;
            acc       <= '0;
            cnt       <= CW'(size - 1);
            iter_done <= 1'b0;
          end else begin
            state <= MDU_IDLE;
          end
        end
        MDU_CALC: begin
          if (!iter_done) begin
            if (is_div_q) begin
              if (!div_trial[size]) begin
                acc[size:0] <= div_trial;
                opa         <= {opa[size-2:0], 1'b1};
              end else begin
                acc[size:0] <= {acc[size-1:0], opa[size-1]};
                opa         <= {opa[size-2:0], 1'b0};
              end
            end else begin
              acc <= {mul_sum, acc[size-1:1]};
              opa <= opa >> 1;
            end
            if (cnt == '0) iter_done <= 1'b1;
            else           cnt       <= cnt - 1'b1;
          end else begin
            // Divide-by-zero bypasses sign correction entirely.
            state  <= MDU_FIX;
            done_q <= 1'b1;
            hi_q   <= div_by_zero ? src1_raw : fix_hi;
            lo_q   <= div_by_zero ? '1       : fix_lo;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign mdu.busy_o = (state != MDU_IDLE);
  assign mdu.done_o = done_q;
  assign mdu.hi_o   = hi_q;
  assign mdu.lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases plus random ops checked
// against an arithmetic reference model, latency, ignored start, back-to-back
// start and asynchronous reset abort.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  mul_div_unit_if #(.size(32)) mdu_bus ();

  mul_div_unit #(.size(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mdu   (mdu_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic from the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic               sg;
    logic signed [31:0] sa, sb;
`ifdef MDU_SIGNED_EN
    sg = ~op[0];
`else
    sg = 1'b0;
`endif
    if (!op[1]) begin
      if (sg) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; the DUT samples start on the next posedge (E0),
  // so done must be seen at the negedge 34 cycles later.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    mdu_bus.start_i = 1'b1;
    mdu_bus.op_i    = op;
    mdu_bus.src1_i  = a;
    mdu_bus.src2_i  = b;
    exp_q.push_back('{exp, cyc + 34});
    @(negedge clk);
    mdu_bus.start_i = 1'b0;
    mdu_bus.op_i    = 2'($urandom);
    mdu_bus.src1_i  = $urandom;
    mdu_bus.src2_i  = $urandom;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!mdu_bus.done_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!mdu_bus.done_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done_o never asserted, got 0 expected 1", name);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mdu_bus.done_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 expected 0 at cycle %0d hi=%h lo=%h",
                 cyc, mdu_bus.hi_o, mdu_bus.lo_o);
      end else begin
        e = exp_q.pop_front();
        check("result_hi_lo", {mdu_bus.hi_o, mdu_bus.lo_o}, e.res);
        check("done_latency", 64'(cyc), 64'(e.cyc));
        check("busy_at_done", 64'(mdu_bus.busy_o), 64'd1);
      end
    end
  end

  initial begin
    int ndone;
    mdu_bus.start_i = 1'b0;
    mdu_bus.op_i    = 2'b00;
    mdu_bus.src1_i  = '0;
    mdu_bus.src2_i  = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(mdu_bus.busy_o), 64'd0);
    check("reset_done", 64'(mdu_bus.done_o), 64'd0);
    check("reset_hi",   64'(mdu_bus.hi_o),   64'd0);
    check("reset_lo",   64'(mdu_bus.lo_o),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(mdu_bus.busy_o), 64'd0);

    // Directed cases
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    check("busy_in_calc", 64'(mdu_bus.busy_o), 64'd1);
    wait_done("multu_max");
`ifdef MDU_SIGNED_EN
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
`else
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, {32'h0000_0004, 32'hFFFF_FFF1});
`endif
    wait_done("mult_neg3x5");
    issue(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_done("divu_100_7");
`ifdef MDU_SIGNED_EN
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC});
`endif
    wait_done("div_neg7_2");
    issue(MDU_DIV, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF});
    wait_done("div_by_zero");
`ifdef MDU_SIGNED_EN
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
`else
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0});
`endif
    wait_done("div_overflow");

    // Start while busy is ignored; start in the done cycle is accepted.
    repeat (2) @(negedge clk);
    issue(MDU_DIVU, 32'd1000, 32'd33, model(MDU_DIVU, 32'd1000, 32'd33));
    repeat (9) @(negedge clk);
    mdu_bus.start_i = 1'b1;
    mdu_bus.op_i    = MDU_MULT;
    mdu_bus.src1_i  = 32'h0000_7777;
    mdu_bus.src2_i  = 32'h0000_0003;
    @(negedge clk);
    mdu_bus.start_i = 1'b0;
    wait_done("ignored_start");
    issue(MDU_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, model(MDU_MULTU, 32'hDEAD_BEEF, 32'h1234_5678));
    wait_done("back_to_back");

    // Random ops, mostly back to back with occasional idle gaps.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, a, b, model(op, a, b));
      wait_done("random");
    end

    // Asynchronous reset in the middle of a MULT, after a nonzero result.
    issue(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_done("pre_reset");
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, model(MDU_MULT, 32'hFFFF_FFFD, 32'd5));
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(mdu_bus.busy_o), 64'd0);
    check("async_rst_hi",   64'(mdu_bus.hi_o),   64'd0);
    check("async_rst_lo",   64'(mdu_bus.lo_o),   64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mdu_bus.done_o) ndone++;
    end
    check("no_done_after_rst", 64'(ndone), 64'd0);
    check("idle_after_rst", 64'(mdu_bus.busy_o), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
